// File: rtl/spi_bitrev_slave.sv
// SPI slave that receives a WIDTH-bit word and returns it bit-reversed in the next WIDTH bits.
// Latency: sck edge to action SYNC_STAGES+1 core cycles; rx_data/rx_valid on the WIDTH-th sample edge.
// Backpressure: none; the SPI master owns the pace, sck phases must last >= SYNC_STAGES+2 cycles.
module spi_bitrev_slave #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             abort,
    output logic [15:0]      xfer_cnt
);

    localparam int            CW          = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST        = CW'(WIDTH - 1);
    localparam logic          SCK_IDLE    = (CPOL != 0);
    localparam bit            SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {IDLE, RX, TX} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sck_sr, ss_sr, mosi_sr;
    logic                   sck_s, ss_s, mosi_s, sck_q;
    logic                   sample_edge, shift_edge;
    logic [WIDTH-1:0]       shreg, tx_q, rx_word, rx_rev;
    logic [CW-1:0]          bitcnt;
    logic                   clear, done, cnt_inc, rx_shift, tx_shift, abort_nxt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sck_sr  <= {SYNC_STAGES{SCK_IDLE}};
            ss_sr   <= {SYNC_STAGES{1'b1}};
            mosi_sr <= '0;
            sck_q   <= SCK_IDLE;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
            ss_sr   <= {ss_sr[SYNC_STAGES-2:0], ss};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sck_q   <= sck_s;
        end
    end

    assign sck_s  = sck_sr[SYNC_STAGES-1];
    assign ss_s   = ss_sr[SYNC_STAGES-1];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    assign sample_edge = SAMPLE_RISE ? (sck_s & ~sck_q) : (~sck_s & sck_q);
    assign shift_edge  = SAMPLE_RISE ? (~sck_s & sck_q) : (sck_s & ~sck_q);

    assign rx_word = {shreg[WIDTH-2:0], mosi_s};

    always_comb begin
        rx_rev = '0;
        for (int i = 0; i < WIDTH; i++) rx_rev[i] = rx_word[WIDTH-1-i];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // ss release has priority over any edge arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        done      = 1'b0;
        cnt_inc   = 1'b0;
        rx_shift  = 1'b0;
        tx_shift  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!ss_s) begin
                    state_nxt = RX;
                    clear     = 1'b1;
                end
            end
            RX: begin
                if (ss_s) begin
                    state_nxt = IDLE;
                    clear     = 1'b1;
                    abort_nxt = (bitcnt != '0);
                end else if (sample_edge) begin
                    if (bitcnt == LAST) begin
                        state_nxt = TX;
                        done      = 1'b1;
                    end else begin
                        cnt_inc  = 1'b1;
                        rx_shift = 1'b1;
                    end
                end
            end
            TX: begin
                if (ss_s) begin
                    state_nxt = IDLE;
                    clear     = 1'b1;
                    abort_nxt = 1'b1;
                end else begin
                    tx_shift = shift_edge;
                    if (sample_edge) begin
                        if (bitcnt == LAST) begin
                            state_nxt = RX;
                            clear     = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                clear     = 1'b1;
            end
        endcase
    end

    // tx_q is consumed MSB first by shifting, one bit per shift edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            miso     <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            abort    <= 1'b0;
            xfer_cnt <= '0;
            shreg    <= '0;
            tx_q     <= '0;
            bitcnt   <= '0;
        end else begin
            rx_valid <= done;
            abort    <= abort_nxt;

            if (state_nxt != TX) miso <= 1'b1;
            else if (tx_shift)   miso <= tx_q[WIDTH-1];

            if (done)          tx_q <= rx_rev;
            else if (tx_shift) tx_q <= {tx_q[WIDTH-2:0], 1'b0};

            if (clear)         shreg <= '0;
            else if (rx_shift) shreg <= rx_word;

            if (clear || done) bitcnt <= '0;
            else if (cnt_inc)  bitcnt <= bitcnt + 1'b1;

            if (done) begin
                rx_data  <= rx_word;
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Bench: four WIDTH=8 instances (modes 0..3) and one WIDTH=16 mode-0 instance driven by a bit-banged master.
module tb_spi_bitrev_slave;

    localparam int H = 6;

    logic        clock = 1'b0;
    logic        resetn;
    logic        lead;
    logic        mosi;
    logic [4:0]  ss;
    logic [4:0]  miso, rx_valid, abort;
    logic [7:0]  rxd8 [4];
    logic [15:0] rxd16;
    logic [15:0] xc [5];

    always #5 clock = ~clock;

    spi_bitrev_slave #(.WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_m0 (
        .clock(clock), .resetn(resetn), .sck(lead), .ss(ss[0]), .mosi(mosi), .miso(miso[0]),
        .rx_data(rxd8[0]), .rx_valid(rx_valid[0]), .abort(abort[0]), .xfer_cnt(xc[0]));
    spi_bitrev_slave #(.WIDTH(8), .CPOL(0), .CPHA(1), .SYNC_STAGES(2)) u_m1 (
        .clock(clock), .resetn(resetn), .sck(lead), .ss(ss[1]), .mosi(mosi), .miso(miso[1]),
        .rx_data(rxd8[1]), .rx_valid(rx_valid[1]), .abort(abort[1]), .xfer_cnt(xc[1]));
    spi_bitrev_slave #(.WIDTH(8), .CPOL(1), .CPHA(0), .SYNC_STAGES(2)) u_m2 (
        .clock(clock), .resetn(resetn), .sck(~lead), .ss(ss[2]), .mosi(mosi), .miso(miso[2]),
        .rx_data(rxd8[2]), .rx_valid(rx_valid[2]), .abort(abort[2]), .xfer_cnt(xc[2]));
    spi_bitrev_slave #(.WIDTH(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_m3 (
        .clock(clock), .resetn(resetn), .sck(~lead), .ss(ss[3]), .mosi(mosi), .miso(miso[3]),
        .rx_data(rxd8[3]), .rx_valid(rx_valid[3]), .abort(abort[3]), .xfer_cnt(xc[3]));
    spi_bitrev_slave #(.WIDTH(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_w16 (
        .clock(clock), .resetn(resetn), .sck(lead), .ss(ss[4]), .mosi(mosi), .miso(miso[4]),
        .rx_data(rxd16), .rx_valid(rx_valid[4]), .abort(abort[4]), .xfer_cnt(xc[4]));

    typedef struct {
        int          k;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        int          k;
        int          w;
        logic [31:0] word;
        logic [31:0] exp_rd;
    } vec_t;

    sb_t   sb [$];
    vec_t  vt [6];
    int    n_chk = 0;
    int    n_pass = 0;
    int    n_rxv [5];
    int    n_abort [5];
    logic [15:0] xc_exp [5];

    function automatic logic [31:0] rxd(int k);
        return (k == 4) ? {16'h0, rxd16} : {24'h0, rxd8[k]};
    endfunction

    function automatic bit cpha(int k);
        return (k == 1) || (k == 3);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard side: every rx_valid pulse must match the oldest queued word.
    always @(negedge clock) begin
        for (int k = 0; k < 5; k++) begin
            if (abort[k] === 1'b1) n_abort[k]++;
            if (rx_valid[k] === 1'b1) begin
                sb_t e;
                n_rxv[k]++;
                if (sb.size() == 0) begin
                    chk("unexpected_rx_valid", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("rx_valid_dut", 32'(k), 32'(e.k));
                    chk("rx_data", rxd(k), e.data);
                end
            end
        end
    end

    // CPHA=0: data set before the leading edge, sampled on it; CPHA=1: set on leading, sampled on trailing.
    task automatic bit_x(int k, logic b, output logic r);
        if (!cpha(k)) begin
            mosi = b;
            cyc(H);
            r = miso[k];
            lead = 1'b1;
            cyc(H);
            lead = 1'b0;
        end else begin
            lead = 1'b1;
            mosi = b;
            cyc(H);
            r = miso[k];
            lead = 1'b0;
            cyc(H);
        end
    endtask

    task automatic frame(int k, int w, logic [31:0] word, output logic [31:0] rd);
        logic r;
        rd = '0;
        sb.push_back('{k: k, data: word});
        for (int i = w - 1; i >= 0; i--) bit_x(k, word[i], r);
        for (int i = 0; i < w; i++) begin
            bit_x(k, 1'b0, r);
            rd = {rd[30:0], r};
        end
        xc_exp[k] = xc_exp[k] + 16'd1;
    endtask

    task automatic start(int k);
        ss[k] = 1'b0;
        cyc(H);
    endtask

    task automatic stop(int k);
        cyc(H);
        ss[k] = 1'b1;
        cyc(H);
    endtask

    initial begin
        logic [31:0] rd;
        logic        r;
        int          rxv0, ab0;

        vt[0] = '{k: 0, w: 8,  word: 32'h01,   exp_rd: 32'h80};
        vt[1] = '{k: 3, w: 8,  word: 32'hB4,   exp_rd: 32'h2D};
        vt[2] = '{k: 1, w: 8,  word: 32'hB4,   exp_rd: 32'h2D};
        vt[3] = '{k: 2, w: 8,  word: 32'hB4,   exp_rd: 32'h2D};
        vt[4] = '{k: 0, w: 8,  word: 32'hB4,   exp_rd: 32'h2D};
        vt[5] = '{k: 4, w: 16, word: 32'hA5C3, exp_rd: 32'hC3A5};

        for (int k = 0; k < 5; k++) begin
            n_rxv[k] = 0;
            n_abort[k] = 0;
            xc_exp[k] = '0;
        end
        resetn = 1'b0;
        ss     = '1;
        lead   = 1'b0;
        mosi   = 1'b0;
        cyc(5);
        chk("reset_miso", {27'h0, miso}, 32'h1F);
        chk("reset_rx_data0", rxd(0), 32'h0);
        chk("reset_xfer_cnt4", {16'h0, xc[4]}, 32'h0);
        chk("reset_flags", {22'h0, rx_valid, abort}, 32'h0);
        resetn = 1'b1;
        cyc(5);

        for (int v = 0; v < 6; v++) begin
            start(vt[v].k);
            frame(vt[v].k, vt[v].w, vt[v].word, rd);
            stop(vt[v].k);
            chk($sformatf("read_v%0d", v), rd, vt[v].exp_rd);
            chk($sformatf("miso_idle_v%0d", v), {31'h0, miso[vt[v].k]}, 32'h1);
            chk($sformatf("xfer_cnt_v%0d", v), {16'h0, xc[vt[v].k]}, {16'h0, xc_exp[vt[v].k]});
        end

        // Back-to-back 16-bit frames under one ss assertion.
        rxv0 = n_rxv[4];
        start(4);
        frame(4, 16, 32'h1234, rd);
        chk("b2b_read0", rd, 32'h2C48);
        frame(4, 16, 32'h8001, rd);
        chk("b2b_read1", rd, 32'h8001);
        stop(4);
        chk("b2b_rx_valid_count", 32'(n_rxv[4] - rxv0), 32'd2);
        chk("b2b_xfer_cnt", {16'h0, xc[4]}, 32'd3);

        // Abort after 5 bits, then a clean frame.
        ab0 = n_abort[0];
        start(0);
        for (int i = 0; i < 5; i++) bit_x(0, 1'b1, r);
        stop(0);
        chk("abort5_pulses", 32'(n_abort[0] - ab0), 32'd1);
        chk("abort5_rx_data_kept", rxd(0), 32'hB4);
        chk("abort5_xfer_cnt", {16'h0, xc[0]}, {16'h0, xc_exp[0]});
        start(0);
        frame(0, 8, 32'h0F, rd);
        stop(0);
        chk("after_abort_read", rd, 32'hF0);
        chk("after_abort_rx_data", rxd(0), 32'h0F);

        // ss rise coincident with the 8th sample edge.
        ab0  = n_abort[0];
        rxv0 = n_rxv[0];
        start(0);
        for (int i = 0; i < 7; i++) bit_x(0, 1'b0, r);
        mosi = 1'b1;
        cyc(H);
        lead  = 1'b1;
        ss[0] = 1'b1;
        cyc(H);
        lead = 1'b0;
        cyc(H);
        chk("coinc_abort", 32'(n_abort[0] - ab0), 32'd1);
        chk("coinc_no_rx_valid", 32'(n_rxv[0] - rxv0), 32'd0);
        chk("coinc_xfer_cnt", {16'h0, xc[0]}, {16'h0, xc_exp[0]});
        chk("coinc_miso", {31'h0, miso[0]}, 32'h1);

        // Counter wrap from 0xFFFF.
        force u_m0.xfer_cnt = 16'hFFFF;
        cyc(1);
        release u_m0.xfer_cnt;
        cyc(1);
        chk("preload_xfer_cnt", {16'h0, xc[0]}, 32'hFFFF);
        start(0);
        frame(0, 8, 32'h3C, rd);
        stop(0);
        chk("wrap_read", rd, 32'h3C);
        chk("wrap_xfer_cnt", {16'h0, xc[0]}, 32'h0);

        // Reset mid-TX: immediate return to reset values, no abort pulse.
        ab0 = n_abort[0];
        start(0);
        sb.push_back('{k: 0, data: 32'h81});
        for (int i = 7; i >= 0; i--) bit_x(0, (i == 7) || (i == 0), r);
        for (int i = 0; i < 3; i++) bit_x(0, 1'b0, r);
        chk("pre_reset_xfer_cnt", {16'h0, xc[0]}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("midtx_reset_miso", {31'h0, miso[0]}, 32'h1);
        chk("midtx_reset_xfer_cnt", {16'h0, xc[0]}, 32'h0);
        chk("midtx_reset_rx_data", rxd(0), 32'h0);
        ss[0] = 1'b1;
        cyc(4);
        resetn = 1'b1;
        cyc(4);
        chk("midtx_reset_no_abort", 32'(n_abort[0] - ab0), 32'd0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
